// File: rtl/cfg_strap_capture.sv
// Boot-strap capture and reset-release controller: samples strap buses during reset,
// checks their stability, issues a stretched core reset and serialises captured channels.
module cfg_strap_capture #(
    parameter int unsigned WIDTH         = 8,
    parameter int unsigned NUM_CH        = 4,
    parameter int unsigned STABLE_CYCLES = 4,
    parameter int unsigned RST_STRETCH   = 2,
    localparam int unsigned RDW          = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_CH*WIDTH-1:0]   cap_in,
    output logic                      rst_n_core,
    output logic [NUM_CH*WIDTH-1:0]   cfg_out,
    output logic                      cfg_valid,
    output logic                      cfg_stable,
    input  logic                      rd_start,
    input  logic [RDW-1:0]            rd_ch,
    output logic                      rd_bit,
    output logic                      rd_busy
);

    localparam int unsigned TOT = NUM_CH * WIDTH;
    localparam int unsigned SW  = $clog2(STABLE_CYCLES + 1);
    localparam int unsigned STW = (RST_STRETCH > 0) ? $clog2(RST_STRETCH + 1) : 1;
    localparam int unsigned CW  = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [SW-1:0]  STAB_MAX = SW'(STABLE_CYCLES);
    localparam logic [STW-1:0] STR_MAX  = STW'(RST_STRETCH);
    localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_RESET,
        S_STRETCH,
        S_RUN
    } state_t;

    state_t           state_q, state_d;
    logic [TOT-1:0]   shadow_q, shadow_d;
    logic [SW-1:0]    stab_q, stab_d, stab_rst;
    logic [STW-1:0]   str_q, str_d;
    logic [TOT-1:0]   cfg_q, cfg_d;
    logic             stable_q, stable_d;
    logic             valid_q, valid_d;
    logic             core_q, core_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [CW-1:0]    bcnt_q, bcnt_d;
    logic             busy_q, busy_d;
    logic             bit_q, bit_d;
    logic [WIDTH-1:0] ch_val;
    int unsigned      sel;

    always_comb begin
        state_d  = state_q;
        shadow_d = shadow_q;
        stab_d   = stab_q;
        str_d    = str_q;
        cfg_d    = cfg_q;
        stable_d = stable_q;
        valid_d  = valid_q;
        core_d   = core_q;
        shift_d  = shift_q;
        bcnt_d   = bcnt_q;
        busy_d   = busy_q;
        bit_d    = bit_q;

        // Saturating count of consecutive identical samples, applied on reset edges
        stab_rst = '0;
        if (cap_in == shadow_q) begin
            stab_rst = (stab_q == STAB_MAX) ? stab_q : stab_q + SW'(1);
        end

        sel = 32'(rd_ch);
        if (sel >= NUM_CH) begin
            sel = 0;
        end
        ch_val = cfg_q[sel*WIDTH +: WIDTH];

        case (state_q)
            S_RESET: begin
                cfg_d    = shadow_q;
                stable_d = (stab_q == STAB_MAX);
                shadow_d = '0;
                stab_d   = '0;
                if (RST_STRETCH == 0) begin
                    state_d = S_RUN;
                    core_d  = 1'b1;
                    valid_d = 1'b1;
                end else begin
                    state_d = S_STRETCH;
                    str_d   = STW'(1);
                end
            end
            S_STRETCH: begin
                if (str_q == STR_MAX) begin
                    state_d = S_RUN;
                    core_d  = 1'b1;
                    valid_d = 1'b1;
                end else begin
                    str_d = str_q + STW'(1);
                end
            end
            S_RUN: begin
                // The final shift cycle doubles as an idle cycle so back-to-back reads have no gap
                if (busy_q && (bcnt_q != '0)) begin
                    bcnt_d  = bcnt_q - CW'(1);
                    shift_d = shift_q << 1;
                    bit_d   = shift_d[WIDTH-1];
                end else if (rd_start) begin
                    shift_d = ch_val;
                    bit_d   = ch_val[WIDTH-1];
                    busy_d  = 1'b1;
                    bcnt_d  = CNT_LAST;
                end else begin
                    shift_d = '0;
                    bit_d   = 1'b0;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                state_d = S_RESET;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_RESET;
            shadow_q <= cap_in;
            stab_q   <= stab_rst;
            str_q    <= '0;
            cfg_q    <= '0;
            stable_q <= 1'b0;
            valid_q  <= 1'b0;
            core_q   <= 1'b0;
            shift_q  <= '0;
            bcnt_q   <= '0;
            busy_q   <= 1'b0;
            bit_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            shadow_q <= shadow_d;
            stab_q   <= stab_d;
            str_q    <= str_d;
            cfg_q    <= cfg_d;
            stable_q <= stable_d;
            valid_q  <= valid_d;
            core_q   <= core_d;
            shift_q  <= shift_d;
            bcnt_q   <= bcnt_d;
            busy_q   <= busy_d;
            bit_q    <= bit_d;
        end
    end

    assign rst_n_core = core_q;
    assign cfg_out    = cfg_q;
    assign cfg_valid  = valid_q;
    assign cfg_stable = stable_q;
    assign rd_bit     = bit_q;
    assign rd_busy    = busy_q;

endmodule

// File: tb/tb_cfg_strap_capture.sv
// Directed bench for cfg_strap_capture: default, single-bit and five-channel instances,
// with expected captures and serial bits queued at stimulus time and popped on output.
module tb_cfg_strap_capture;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: defaults
    logic        rst_n_a, rd_start_a, core_a, valid_a, stable_a, bit_a, busy_a;
    logic [31:0] cap_a, cfg_a;
    logic [1:0]  rd_ch_a;
    // Instance B: minimal single-bit configuration
    logic        rst_n_b, rd_start_b, core_b, valid_b, stable_b, bit_b, busy_b;
    logic [0:0]  cap_b, cfg_b, rd_ch_b;
    // Instance C: five channels so out-of-range channel numbers are representable
    logic        rst_n_c, rd_start_c, core_c, valid_c, stable_c, bit_c, busy_c;
    logic [19:0] cap_c, cfg_c;
    logic [2:0]  rd_ch_c;

    cfg_strap_capture #(.WIDTH(8), .NUM_CH(4), .STABLE_CYCLES(4), .RST_STRETCH(2)) u_a (
        .clk(clk), .rst_n(rst_n_a), .cap_in(cap_a), .rst_n_core(core_a), .cfg_out(cfg_a),
        .cfg_valid(valid_a), .cfg_stable(stable_a), .rd_start(rd_start_a), .rd_ch(rd_ch_a),
        .rd_bit(bit_a), .rd_busy(busy_a));

    cfg_strap_capture #(.WIDTH(1), .NUM_CH(1), .STABLE_CYCLES(1), .RST_STRETCH(0)) u_b (
        .clk(clk), .rst_n(rst_n_b), .cap_in(cap_b), .rst_n_core(core_b), .cfg_out(cfg_b),
        .cfg_valid(valid_b), .cfg_stable(stable_b), .rd_start(rd_start_b), .rd_ch(rd_ch_b),
        .rd_bit(bit_b), .rd_busy(busy_b));

    cfg_strap_capture #(.WIDTH(4), .NUM_CH(5), .STABLE_CYCLES(2), .RST_STRETCH(1)) u_c (
        .clk(clk), .rst_n(rst_n_c), .cap_in(cap_c), .rst_n_core(core_c), .cfg_out(cfg_c),
        .cfg_valid(valid_c), .cfg_stable(stable_c), .rd_start(rd_start_c), .rd_ch(rd_ch_c),
        .rd_bit(bit_c), .rd_busy(busy_c));

    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] sb[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_sb(input string tag, input logic [31:0] obs);
        logic [31:0] exp;
        if (sb.size() == 0) begin
            n_cmp++;
            n_err++;
            $error("FAIL %s: observed=%0h expected=<scoreboard empty>", tag, obs);
        end else begin
            exp = sb.pop_front();
            chk(tag, obs, exp);
        end
    endtask

    task automatic set_rd(input int which, input logic s, input logic [2:0] ch);
        case (which)
            0: begin rd_start_a = s; rd_ch_a = ch[1:0]; end
            1: begin rd_start_b = s; rd_ch_b = ch[0:0]; end
            default: begin rd_start_c = s; rd_ch_c = ch; end
        endcase
    endtask

    function automatic logic [31:0] busy_of(input int which);
        return (which == 0) ? 32'(busy_a) : (which == 1) ? 32'(busy_b) : 32'(busy_c);
    endfunction

    function automatic logic [31:0] bit_of(input int which);
        return (which == 0) ? 32'(bit_a) : (which == 1) ? 32'(bit_b) : 32'(bit_c);
    endfunction

    // mid >= 0 pulses rd_start (another channel) after that bit, while still busy
    task automatic readback(input int which, input logic [2:0] ch, input int w,
                            input logic [31:0] val, input int mid, input string tag);
        for (int i = w - 1; i >= 0; i--) sb.push_back(32'(val[i]));
        set_rd(which, 1'b1, ch);
        tick();
        set_rd(which, 1'b0, 3'd0);
        for (int i = 0; i < w; i++) begin
            chk({tag, "_busy"}, busy_of(which), 32'd1);
            chk_sb({tag, "_bit"}, bit_of(which));
            if (i == mid) set_rd(which, 1'b1, 3'd1);
            tick();
            if (i == mid) set_rd(which, 1'b0, 3'd0);
        end
        chk({tag, "_end_busy"}, busy_of(which), 32'd0);
        chk({tag, "_end_bit"}, bit_of(which), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n_a = 1'b0; rst_n_b = 1'b0; rst_n_c = 1'b0;
        cap_a = 32'hA53C_F00F; cap_b = 1'b1; cap_c = 20'h4_3219;
        rd_start_a = 1'b0; rd_start_b = 1'b0; rd_start_c = 1'b0;
        rd_ch_a = '0; rd_ch_b = '0; rd_ch_c = '0;

        // Defaults: six reset edges with constant straps
        repeat (6) tick();
        chk("a_rst_core", 32'(core_a), 32'd0);
        chk("a_rst_valid", 32'(valid_a), 32'd0);
        chk("a_rst_cfg", cfg_a, 32'd0);
        chk("a_rst_stable", 32'(stable_a), 32'd0);
        chk("a_rst_busy", 32'(busy_a), 32'd0);
        chk("a_rst_bit", 32'(bit_a), 32'd0);

        rst_n_a = 1'b1;
        sb.push_back(32'hA53C_F00F);
        tick();                                   // edge k
        chk_sb("a_cfg_k", cfg_a);
        chk("a_stable_k", 32'(stable_a), 32'd1);
        chk("a_core_k", 32'(core_a), 32'd0);
        chk("a_valid_k", 32'(valid_a), 32'd0);
        cap_a = 32'h0;
        set_rd(0, 1'b1, 3'd2);                    // request during STRETCH
        tick();                                   // edge k+1
        set_rd(0, 1'b0, 3'd0);
        chk("a_rd_in_stretch", 32'(busy_a), 32'd0);
        chk("a_core_k1", 32'(core_a), 32'd0);
        tick();                                   // edge k+2
        chk("a_core_k2", 32'(core_a), 32'd1);
        chk("a_valid_k2", 32'(valid_a), 32'd1);
        chk("a_cfg_frozen", cfg_a, 32'hA53C_F00F);
        chk("a_busy_idle", 32'(busy_a), 32'd0);

        readback(0, 3'd2, 8, 32'h3C, 3, "a_rb_ch2");
        readback(0, 3'd3, 8, 32'hA5, -1, "a_rb_ch3");

        // Reset mid-readback aborts everything on that edge
        set_rd(0, 1'b1, 3'd2);
        tick();
        set_rd(0, 1'b0, 3'd0);
        tick();
        chk("a_abort_pre_busy", 32'(busy_a), 32'd1);
        rst_n_a = 1'b0;
        cap_a = 32'h1111_1111;
        tick();
        chk("a_abort_busy", 32'(busy_a), 32'd0);
        chk("a_abort_bit", 32'(bit_a), 32'd0);
        chk("a_abort_core", 32'(core_a), 32'd0);
        chk("a_abort_valid", 32'(valid_a), 32'd0);
        chk("a_abort_cfg", cfg_a, 32'd0);
        chk("a_abort_stable", 32'(stable_a), 32'd0);

        // Glitch on the second-to-last reset edge
        repeat (3) tick();
        cap_a = 32'h2222_2222;
        tick();
        cap_a = 32'h1111_1111;
        tick();
        rst_n_a = 1'b1;
        tick();
        chk("a_glitch_cfg", cfg_a, 32'h1111_1111);
        chk("a_glitch_stable", 32'(stable_a), 32'd0);

        // Reset reasserted during STRETCH, then a clean recapture
        rst_n_a = 1'b0;
        cap_a = 32'hC0FF_EE42;
        tick();
        chk("a_sabort_core", 32'(core_a), 32'd0);
        chk("a_sabort_valid", 32'(valid_a), 32'd0);
        chk("a_sabort_cfg", cfg_a, 32'd0);
        repeat (5) tick();
        rst_n_a = 1'b1;
        sb.push_back(32'hC0FF_EE42);
        tick();
        chk_sb("a_recap_cfg", cfg_a);
        chk("a_recap_stable", 32'(stable_a), 32'd1);
        chk("a_recap_core_k", 32'(core_a), 32'd0);
        tick();
        chk("a_recap_core_k1", 32'(core_a), 32'd0);
        tick();
        chk("a_recap_core_k2", 32'(core_a), 32'd1);
        chk("a_recap_valid_k2", 32'(valid_a), 32'd1);

        // Instance B: no stretch, single-bit readback
        rst_n_b = 1'b1;
        tick();
        chk("b_core_k", 32'(core_b), 32'd1);
        chk("b_valid_k", 32'(valid_b), 32'd1);
        chk("b_cfg_k", 32'(cfg_b), 32'd1);
        chk("b_stable_k", 32'(stable_b), 32'd1);
        readback(1, 3'd0, 1, 32'h1, -1, "b_rb");
        rst_n_b = 1'b0;                           // one-edge pulse: shadow cleared, sample differs
        tick();
        rst_n_b = 1'b1;
        tick();
        chk("b_pulse_cfg", 32'(cfg_b), 32'd1);
        chk("b_pulse_stable", 32'(stable_b), 32'd0);
        chk("b_pulse_core", 32'(core_b), 32'd1);
        rst_n_b = 1'b0;
        repeat (2) tick();
        rst_n_b = 1'b1;
        tick();
        chk("b_two_stable", 32'(stable_b), 32'd1);

        // Instance C: one-cycle stretch, out-of-range channel numbers
        rst_n_c = 1'b1;
        sb.push_back(32'h4_3219);
        tick();
        chk_sb("c_cfg_k", 32'(cfg_c));
        chk("c_stable_k", 32'(stable_c), 32'd1);
        chk("c_core_k", 32'(core_c), 32'd0);
        tick();
        chk("c_core_k1", 32'(core_c), 32'd1);
        chk("c_valid_k1", 32'(valid_c), 32'd1);
        readback(2, 3'd5, 4, 32'h9, -1, "c_rb_ch5");
        readback(2, 3'd7, 4, 32'h9, -1, "c_rb_ch7");
        readback(2, 3'd4, 4, 32'h4, -1, "c_rb_ch4");

        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
